gt_trace_ifu: RTL and testbench
===============================

GT_TRACE_IFU -- requirements
Module: gt_trace_ifu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of each trace address.
REQ-002 SHALL have parameter DEPTH, default 64: number of trace entries, a power of two of at least 2; IDX_W = log2(DEPTH).
REQ-003 SHALL have parameter WRAP_W, default 16: width of the wrap counter.
REQ-004 Ports SHALL be, clock and reset first:
- GCLK in 1: single clock, rising edge.
- CLEAR in 1: asynchronous, active-high reset.
- WR_EN in 1: trace-memory write strobe.
- WR_IDX in IDX_W: write index.
- WR_DATA in ADDR_W: write data.
- LEN_IN in IDX_W+1: trace length, sampled on START.
- LOOP in 1: wrap mode, sampled on START.
- START in 1: begin playback.
- STOP in 1: abort playback.
- ADDR_RDY in 1: consumer (cache) ready.
- ADDR_OUT out ADDR_W: current trace address.
- ADDR_VLD out 1: ADDR_OUT is valid.
- IDX_OUT out IDX_W: index of ADDR_OUT.
- BUSY out 1: state is RUN.
- DONE out 1: state is DONE.
- WRAP_CNT out WRAP_W: completed loop count.
- WR_ERR out 1: one-cycle pulse when a write is rejected.

Function
REQ-005 SHALL hold a DEPTH x ADDR_W trace memory, written synchronously when WR_EN=1, in state IDLE or DONE only.
REQ-006 A WR_EN asserted in RUN SHALL be ignored and SHALL pulse WR_ERR for one cycle on the next edge.
REQ-007 SHALL implement states IDLE, RUN and DONE.
- IDLE/DONE -> RUN on START with LEN_IN != 0.
- RUN -> DONE when the last entry is transferred and LOOP=0.
- RUN -> IDLE on STOP.
- DONE -> IDLE on STOP.
REQ-008 In IDLE or DONE, START with LEN_IN=0 SHALL be ignored; LEN_IN>DEPTH SHALL be clamped to DEPTH.
REQ-009 On START, the block SHALL latch LEN and LOOP, set idx=0, clear WRAP_CNT, and register ADDR_OUT=mem[0], IDX_OUT=0 and ADDR_VLD=1 on the same edge, giving valid data in the cycle after START.
REQ-010 A transfer SHALL occur in any cycle with ADDR_VLD=1 and ADDR_RDY=1.
REQ-011 On a transfer with idx<LEN-1, the block SHALL set idx=idx+1 and register ADDR_OUT=mem[idx+1], sustaining one transfer per cycle under continuous ADDR_RDY.
REQ-012 While ADDR_VLD=1 and ADDR_RDY=0, ADDR_OUT and IDX_OUT SHALL hold stable.
REQ-013 On a transfer with idx=LEN-1 and LOOP=0, the block SHALL deassert ADDR_VLD on the next edge, enter DONE and hold ADDR_OUT and IDX_OUT.
REQ-014 On a transfer with idx=LEN-1 and LOOP=1, the block SHALL set idx=0, register ADDR_OUT=mem[0] with no bubble, and increment WRAP_CNT, saturating at all-ones.
REQ-015 LEN=1 with LOOP=1 SHALL re-present mem[0] on every transfer.
REQ-016 STOP SHALL take priority over START and over a transfer in the same cycle: ADDR_VLD=0 on the next edge, ADDR_OUT unchanged, state IDLE.
REQ-017 START asserted in RUN SHALL be ignored.
REQ-018 START and WR_EN in the same cycle in IDLE or DONE SHALL both take effect; the START read SHALL return the pre-write contents.
REQ-019 All outputs SHALL be registered; there SHALL be no combinational path from ADDR_RDY to ADDR_VLD.

Reset
REQ-020 CLEAR=1 SHALL asynchronously force:
- state IDLE.
- ADDR_OUT=0, IDX_OUT=0, ADDR_VLD=0.
- WRAP_CNT=0, WR_ERR=0, latched LEN=0, LOOP=0.
REQ-021 Trace memory contents SHALL NOT be reset.
REQ-022 CLEAR asserted mid-RUN SHALL abort playback without any further transfer.
REQ-023 After CLEAR deasserts, playback SHALL require a new START.

Structure
REQ-024 Package gt_ifu_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default values of ADDR_W, DEPTH and WRAP_W.
REQ-025 Storage SHALL be the sub-module gt_trace_mem: one synchronous write port and one combinational read port, parameterised by ADDR_W and DEPTH.
REQ-026 The index, LEN and WRAP counters and the FSM SHALL reside in gt_trace_ifu.

Verification
REQ-027 Load idx0..2 = 0x41, 0x442, 0xC3; LEN_IN=3, LOOP=0, ADDR_RDY=1, START -> 0x41, 0x442, 0xC3 on three consecutive cycles, IDX_OUT 0,1,2, then DONE=1 and ADDR_VLD=0.
REQ-028 Same load with LOOP=1, ADDR_RDY=1 for 7 cycles -> sequence 0x41, 0x442, 0xC3, 0x41, 0x442, 0xC3, 0x41 with no bubble, WRAP_CNT=2.
REQ-029 ADDR_RDY=0 for 3 cycles while IDX_OUT=1 -> ADDR_OUT holds 0x442 throughout, and 0xC3 follows one cycle after ADDR_RDY=1.
REQ-030 WR_EN at idx0 with 0x999 during RUN -> WR_ERR one-cycle pulse; the next loop still presents 0x41.
REQ-031 STOP and a transfer in the same cycle -> ADDR_VLD=0 next cycle, IDX_OUT unchanged, state IDLE; CLEAR mid-RUN -> all outputs 0 immediately, with no edge needed.
REQ-032 LEN_IN=0 with START -> remains IDLE; LEN_IN=DEPTH+1 with START -> DEPTH entries played, last IDX_OUT = DEPTH-1.

Source files
------------

// File: rtl/gt_ifu_pkg.sv
// Shared state encoding and parameter defaults for the trace-driven fetch unit.
package gt_ifu_pkg;

  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned DepthDefault = 64;
  localparam int unsigned WrapWDefault = 16;

  // Bit 0 is BUSY and bit 1 is DONE, so both outputs come straight off the state flops.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/gt_trace_mem.sv
// Trace storage: one synchronous write port and one combinational read port, no reset.
module gt_trace_mem #(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [ADDR_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [ADDR_W-1:0] o_rd_data
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_idx] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/gt_trace_ifu.sv
// Replays a stored address trace to a cache with valid/ready handshaking and optional wrap.
module gt_trace_ifu
  import gt_ifu_pkg::*;
#(
  parameter  int unsigned ADDR_W = AddrWDefault,
  parameter  int unsigned DEPTH  = DepthDefault,
  parameter  int unsigned WRAP_W = WrapWDefault,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              GCLK,
  input  logic              CLEAR,
  input  logic              WR_EN,
  input  logic [IDX_W-1:0]  WR_IDX,
  input  logic [ADDR_W-1:0] WR_DATA,
  input  logic [IDX_W:0]    LEN_IN,
  input  logic              LOOP,
  input  logic              START,
  input  logic              STOP,
  input  logic              ADDR_RDY,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic              ADDR_VLD,
  output logic [IDX_W-1:0]  IDX_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [WRAP_W-1:0] WRAP_CNT,
  output logic              WR_ERR
);

  localparam logic [IDX_W:0] LenMax = (IDX_W+1)'(DEPTH);

  state_e            r_state, w_state_d;
  logic [IDX_W-1:0]  r_idx, w_idx_d;
  logic [IDX_W:0]    r_len, w_len_d;
  logic              r_loop, w_loop_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_vld, w_vld_d;
  logic [WRAP_W-1:0] r_wrap, w_wrap_d;
  logic              r_wr_err;

  logic              w_xfer, w_last, w_mem_we;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [ADDR_W-1:0] w_rd_data;

  assign w_xfer   = r_vld && ADDR_RDY;
  assign w_last   = ((IDX_W+1)'(r_idx) + (IDX_W+1)'(1)) == r_len;
  assign w_mem_we = WR_EN && (r_state != StRun);
  // Start and wrap both read entry 0; otherwise look one entry ahead.
  assign w_rd_idx = (r_state == StRun && !w_last) ? r_idx + IDX_W'(1) : '0;

  gt_trace_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (GCLK),
    .i_we      (w_mem_we),
    .i_wr_idx  (WR_IDX),
    .i_wr_data (WR_DATA),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_len_d   = r_len;
    w_loop_d  = r_loop;
    w_addr_d  = r_addr;
    w_vld_d   = r_vld;
    w_wrap_d  = r_wrap;
    if (STOP) begin
      w_state_d = StIdle;
      w_vld_d   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (START && LEN_IN != '0) begin
            w_state_d = StRun;
            w_len_d   = (LEN_IN > LenMax) ? LenMax : LEN_IN;
            w_loop_d  = LOOP;
            w_idx_d   = '0;
            w_wrap_d  = '0;
            w_addr_d  = w_rd_data;
            w_vld_d   = 1'b1;
          end
        end
        StRun: begin
          if (w_xfer) begin
            if (!w_last) begin
              w_idx_d  = r_idx + IDX_W'(1);
              w_addr_d = w_rd_data;
            end else if (r_loop) begin
              w_idx_d  = '0;
              w_addr_d = w_rd_data;
              if (r_wrap != '1) w_wrap_d = r_wrap + WRAP_W'(1);
            end else begin
              w_state_d = StDone;
              w_vld_d   = 1'b0;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge GCLK or posedge CLEAR) begin
    if (CLEAR) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_len    <= '0;
      r_loop   <= 1'b0;
      r_addr   <= '0;
      r_vld    <= 1'b0;
      r_wrap   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_len    <= w_len_d;
      r_loop   <= w_loop_d;
      r_addr   <= w_addr_d;
      r_vld    <= w_vld_d;
      r_wrap   <= w_wrap_d;
      r_wr_err <= WR_EN && (r_state == StRun);
    end
  end

  assign ADDR_OUT = r_addr;
  assign ADDR_VLD = r_vld;
  assign IDX_OUT  = r_idx;
  assign BUSY     = r_state[0];
  assign DONE     = r_state[1];
  assign WRAP_CNT = r_wrap;
  assign WR_ERR   = r_wr_err;

endmodule

// File: tb/tb_gt_trace_ifu.sv
// Directed bench for gt_trace_ifu with default parameters.
module tb_gt_trace_ifu;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int WRAP_W = 16;
  localparam int IDX_W  = 6;

  logic              GCLK = 1'b0;
  logic              CLEAR;
  logic              WR_EN;
  logic [IDX_W-1:0]  WR_IDX;
  logic [ADDR_W-1:0] WR_DATA;
  logic [IDX_W:0]    LEN_IN;
  logic              LOOP, START, STOP, ADDR_RDY;
  logic [ADDR_W-1:0] ADDR_OUT;
  logic              ADDR_VLD;
  logic [IDX_W-1:0]  IDX_OUT;
  logic              BUSY, DONE;
  logic [WRAP_W-1:0] WRAP_CNT;
  logic              WR_ERR;

  int checks = 0;
  int passes = 0;

  gt_trace_ifu #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WRAP_W (WRAP_W)
  ) dut (
    .GCLK     (GCLK),
    .CLEAR    (CLEAR),
    .WR_EN    (WR_EN),
    .WR_IDX   (WR_IDX),
    .WR_DATA  (WR_DATA),
    .LEN_IN   (LEN_IN),
    .LOOP     (LOOP),
    .START    (START),
    .STOP     (STOP),
    .ADDR_RDY (ADDR_RDY),
    .ADDR_OUT (ADDR_OUT),
    .ADDR_VLD (ADDR_VLD),
    .IDX_OUT  (IDX_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .WRAP_CNT (WRAP_CNT),
    .WR_ERR   (WR_ERR)
  );

  always #5 GCLK = ~GCLK;

  task automatic tick();
    @(posedge GCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] trace_val(input int i);
    case (i)
      0: return 32'h41;
      1: return 32'h442;
      2: return 32'hC3;
      default: return 32'h1000 + i;
    endcase
  endfunction

  logic [31:0] seq7 [7];

  initial begin
    seq7 = '{32'h41, 32'h442, 32'hC3, 32'h41, 32'h442, 32'hC3, 32'h41};
    CLEAR = 1'b1; WR_EN = 1'b0; WR_IDX = '0; WR_DATA = '0; LEN_IN = '0;
    LOOP = 1'b0; START = 1'b0; STOP = 1'b0; ADDR_RDY = 1'b0;
    tick();
    chk("rst_vld", ADDR_VLD, 0);
    chk("rst_addr", ADDR_OUT, 0);
    chk("rst_idx", IDX_OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_wrap", WRAP_CNT, 0);
    chk("rst_wrerr", WR_ERR, 0);
    CLEAR = 1'b0;

    // Load trace memory.
    for (int i = 0; i < DEPTH; i++) begin
      WR_EN = 1'b1; WR_IDX = IDX_W'(i); WR_DATA = trace_val(i);
      tick();
    end
    WR_EN = 1'b0;

    // Single pass, LEN=3.
    LEN_IN = 3; LOOP = 1'b0; ADDR_RDY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    chk("p_busy", BUSY, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p_addr%0d", i), ADDR_OUT, trace_val(i));
      chk($sformatf("p_idx%0d", i), IDX_OUT, i);
      chk($sformatf("p_vld%0d", i), ADDR_VLD, 1);
      tick();
    end
    chk("p_done", DONE, 1);
    chk("p_vld_end", ADDR_VLD, 0);
    chk("p_addr_hold", ADDR_OUT, 32'hC3);
    chk("p_idx_hold", IDX_OUT, 2);

    // Looping pass from DONE.
    LOOP = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("l_addr%0d", i), ADDR_OUT, seq7[i]);
      chk($sformatf("l_vld%0d", i), ADDR_VLD, 1);
      if (i < 6) tick();
    end
    chk("l_wrap", WRAP_CNT, 2);

    // Backpressure at idx 1.
    tick();
    chk("bp_idx", IDX_OUT, 1);
    ADDR_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_addr%0d", i), ADDR_OUT, 32'h442);
      chk($sformatf("bp_idx%0d", i), IDX_OUT, 1);
    end
    ADDR_RDY = 1'b1;
    tick();
    chk("bp_resume", ADDR_OUT, 32'hC3);

    // Rejected write during RUN.
    WR_EN = 1'b1; WR_IDX = 0; WR_DATA = 32'h999;
    tick();
    WR_EN = 1'b0;
    chk("we_err", WR_ERR, 1);
    chk("we_addr", ADDR_OUT, 32'h41);
    chk("we_wrap", WRAP_CNT, 3);
    tick();
    chk("we_err_clr", WR_ERR, 0);
    tick();
    tick();
    chk("we_mem_kept", ADDR_OUT, 32'h41);

    // STOP together with a transfer.
    tick();
    chk("st_pre_idx", IDX_OUT, 1);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("st_vld", ADDR_VLD, 0);
    chk("st_idx", IDX_OUT, 1);
    chk("st_addr", ADDR_OUT, 32'h442);
    chk("st_busy", BUSY, 0);
    chk("st_done", DONE, 0);

    // Asynchronous CLEAR mid-run.
    LEN_IN = 3; LOOP = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("cl_pre", ADDR_OUT, 32'h442);
    #2 CLEAR = 1'b1;
    #1;
    chk("cl_addr", ADDR_OUT, 0);
    chk("cl_vld", ADDR_VLD, 0);
    chk("cl_idx", IDX_OUT, 0);
    chk("cl_busy", BUSY, 0);
    chk("cl_wrap", WRAP_CNT, 0);
    #1 CLEAR = 1'b0;
    tick();
    chk("cl_stay_vld", ADDR_VLD, 0);
    chk("cl_stay_busy", BUSY, 0);

    // LEN_IN=0 is ignored.
    LEN_IN = 0; START = 1'b1;
    tick();
    START = 1'b0;
    chk("z_busy", BUSY, 0);
    chk("z_vld", ADDR_VLD, 0);

    // LEN_IN above DEPTH is clamped.
    LEN_IN = 7'(DEPTH + 1); LOOP = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("c_idx%0d", i), IDX_OUT, i);
      chk($sformatf("c_addr%0d", i), ADDR_OUT, trace_val(i));
      tick();
    end
    chk("c_done", DONE, 1);
    chk("c_vld", ADDR_VLD, 0);
    chk("c_last_idx", IDX_OUT, DEPTH - 1);

    // START with a simultaneous write reads pre-write data; LEN=1 loop repeats entry 0.
    LEN_IN = 1; LOOP = 1'b1; START = 1'b1;
    WR_EN = 1'b1; WR_IDX = 0; WR_DATA = 32'h77;
    tick();
    START = 1'b0; WR_EN = 1'b0;
    chk("sw_addr", ADDR_OUT, 32'h41);
    chk("sw_err", WR_ERR, 0);
    tick();
    chk("sw_new", ADDR_OUT, 32'h77);
    chk("sw_idx", IDX_OUT, 0);
    chk("sw_wrap", WRAP_CNT, 1);
    tick();
    chk("sw_wrap2", WRAP_CNT, 2);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("sw_stop", ADDR_VLD, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
